// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the data-memory controller.
// Lanes are 32-bit little-endian: byte offset 0 is bits [7:0].
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RD_WAIT   = 2'b01,
    RMW_READ  = 2'b10,
    RMW_WRITE = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // The unused encoding 2'b11 is treated as a full word
  function automatic size_e size_of(input logic [1:0] f3_lo);
    case (f3_lo)
      2'b00:   size_of = SZ_B;
      2'b01:   size_of = SZ_H;
      default: size_of = SZ_W;
    endcase
  endfunction

  function automatic logic [1:0] align_off(input logic [1:0] off, input size_e sz);
    case (sz)
      SZ_B:    align_off = off;
      SZ_H:    align_off = {off[1], 1'b0};
      default: align_off = 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] off,
                                               input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (f3)
      F3_LB:   lane_extract = {{24{b[7]}}, b};
      F3_LH:   lane_extract = {{16{h[15]}}, h};
      F3_LBU:  lane_extract = {24'h000000, b};
      F3_LHU:  lane_extract = {16'h0000, h};
      default: lane_extract = w;
    endcase
  endfunction

  function automatic logic [31:0] lane_insert(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [1:0] off, input size_e sz);
    logic [31:0] r;
    r = old_w;
    case (sz)
      SZ_B:    r[{off, 3'b000} +: 8] = new_w[7:0];
      SZ_H:    r[{off[1], 4'b0000} +: 16] = new_w[15:0];
      default: r = new_w;
    endcase
    lane_insert = r;
  endfunction

endpackage

// File: rtl/lane_merge.sv
// Combinational byte/halfword insert of store data into a word read back from RAM.
module lane_merge
  import mem_pkg::*;
(
  input  logic [31:0] i_old,
  input  logic [31:0] i_new,
  input  logic [1:0]  i_off,
  input  size_e       i_size,
  output logic [31:0] o_word
);

  assign o_word = lane_insert(i_old, i_new, i_off, i_size);

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: zero-stall word stores, 2-cycle loads, 3-cycle read-modify-write
// sub-word stores. Optional macro MISALIGN_TRAP_EN traps misaligned half/word accesses.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int WADDR_W = 10
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [31:0]        daddr,
  input  logic [DATA_W-1:0]  ddata_w,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic [2:0]         funct3,
  output logic [DATA_W-1:0]  ddata_r,
  output logic               stall,
  output logic               misalign,
  output logic [WADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0]  ram_data,
  output logic               ram_wren,
  output logic               ram_rden,
  input  logic [DATA_W-1:0]  ram_q
);

  state_e            r_state;
  logic [DATA_W-1:0] r_ddata;
  logic [DATA_W-1:0] r_merged;
  size_e             w_size;
  logic [1:0]        w_off;
  logic              w_mis;
  logic              w_req;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_merged;
  logic              w_unused_hi;

  assign w_size      = size_of(funct3[1:0]);
  assign w_req       = MemRead | MemWrite;
  assign ram_address = daddr[WADDR_W+1:2];
  assign w_unused_hi = ^daddr[31:WADDR_W+2];

`ifdef MISALIGN_TRAP_EN
  assign w_mis = ((w_size == SZ_H) && daddr[0]) || ((w_size == SZ_W) && (daddr[1:0] != 2'b00));
  assign w_off = daddr[1:0];
`else
  assign w_mis = 1'b0;
  assign w_off = align_off(daddr[1:0], w_size);
`endif

  assign w_load = lane_extract(ram_q, w_off, funct3);

  lane_merge u_lane_merge (
    .i_old  (ram_q),
    .i_new  (ddata_w),
    .i_off  (w_off),
    .i_size (w_size),
    .o_word (w_merged)
  );

  // Core/RAM handshake is combinational so word stores need no stall cycle
  always_comb begin
    stall    = 1'b0;
    misalign = 1'b0;
    ram_wren = 1'b0;
    ram_rden = 1'b0;
    ram_data = '0;
    ddata_r  = r_ddata;
    if (!RESET_N) begin
      ddata_r = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && w_mis) begin
            misalign = 1'b1;
          end else if (MemWrite && (w_size == SZ_W)) begin
            ram_wren = 1'b1;
            ram_data = ddata_w;
          end else if (w_req) begin
            ram_rden = 1'b1;
            stall    = 1'b1;
          end else begin
            stall = 1'b0;
          end
        end
        RD_WAIT:   ddata_r = w_load;
        RMW_READ:  stall = 1'b1;
        RMW_WRITE: begin
          ram_wren = 1'b1;
          ram_data = r_merged;
        end
        default: stall = 1'b0;
      endcase
    end
  end

  // State, held load result and merged store word
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state  <= IDLE;
      r_ddata  <= '0;
      r_merged <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && w_mis) begin
            r_state <= IDLE;
          end else if (MemWrite && (w_size != SZ_W)) begin
            r_state <= RMW_READ;
          end else if (MemWrite) begin
            r_state <= IDLE;
          end else if (MemRead) begin
            r_state <= RD_WAIT;
          end else begin
            r_state <= IDLE;
          end
        end
        RD_WAIT: begin
          r_ddata <= w_load;
          r_state <= IDLE;
        end
        RMW_READ: begin
          r_merged <= w_merged;
          r_state  <= RMW_WRITE;
        end
        RMW_WRITE: r_state <= IDLE;
        default:   r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a behavioural synchronous RAM.
module tb_data_mem_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [31:0] daddr;
  logic [31:0] ddata_w;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ddata_r;
  logic        stall;
  logic        misalign;
  logic [9:0]  ram_address;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic        ram_rden;
  logic [31:0] ram_q;

  logic [31:0] tb_mem [0:1023];
  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  data_mem_ctrl #(.DATA_W(32), .WADDR_W(10)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .daddr(daddr), .ddata_w(ddata_w),
    .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
    .ddata_r(ddata_r), .stall(stall), .misalign(misalign),
    .ram_address(ram_address), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_rden(ram_rden), .ram_q(ram_q)
  );

  // Synchronous RAM: read data appears one cycle after ram_rden
  always @(posedge CLK) begin
    if (ram_wren) tb_mem[ram_address] <= ram_data;
    if (ram_rden) ram_q <= tb_mem[ram_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] exp);
    @(negedge CLK);
    daddr = a; funct3 = f3; MemRead = 1'b1;
    #1;
    chk({tag, "_stall1"}, {31'd0, stall}, 32'd1);
    chk({tag, "_rden"}, {31'd0, ram_rden}, 32'd1);
    chk({tag, "_mis"}, {31'd0, misalign}, 32'd0);
    @(negedge CLK);
    #1;
    chk({tag, "_stall0"}, {31'd0, stall}, 32'd0);
    chk({tag, "_data"}, ddata_r, exp);
    MemRead = 1'b0;
    @(negedge CLK);
    #1;
    chk({tag, "_hold"}, ddata_r, exp);
  endtask

  initial begin
    RESET_N = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    daddr = 32'h0; ddata_w = 32'h0; funct3 = 3'b010; ram_q = 32'h0;
    for (int i = 0; i < 1024; i++) tb_mem[i] = 32'h0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    #1;
    chk("rst_ddata_r", ddata_r, 32'h0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_wren", {31'd0, ram_wren}, 32'd0);
    chk("rst_rden", {31'd0, ram_rden}, 32'd0);
    chk("rst_mis", {31'd0, misalign}, 32'd0);
    chk("rst_ram_data", ram_data, 32'h0);

    // Zero-stall word store
    @(negedge CLK);
    daddr = 32'h10; ddata_w = 32'hDEADBEEF; funct3 = 3'b010; MemWrite = 1'b1;
    #1;
    chk("sw_wren", {31'd0, ram_wren}, 32'd1);
    chk("sw_addr", {22'd0, ram_address}, 32'd4);
    chk("sw_data", ram_data, 32'hDEADBEEF);
    chk("sw_stall", {31'd0, stall}, 32'd0);
    chk("sw_rden", {31'd0, ram_rden}, 32'd0);
    @(negedge CLK);
    MemWrite = 1'b0;
    #1;
    chk("sw_done_wren", {31'd0, ram_wren}, 32'd0);

    do_load("lb", 32'h13, 3'b000, 32'hFFFFFFDE);
    do_load("lbu", 32'h13, 3'b100, 32'h000000DE);

    // Byte store via read-modify-write
    @(negedge CLK);
    daddr = 32'h11; ddata_w = 32'h00000055; funct3 = 3'b000; MemWrite = 1'b1;
    #1;
    chk("sb_c1_stall", {31'd0, stall}, 32'd1);
    chk("sb_c1_rden", {31'd0, ram_rden}, 32'd1);
    chk("sb_c1_wren", {31'd0, ram_wren}, 32'd0);
    @(negedge CLK);
    #1;
    chk("sb_c2_stall", {31'd0, stall}, 32'd1);
    chk("sb_c2_wren", {31'd0, ram_wren}, 32'd0);
    chk("sb_c2_rden", {31'd0, ram_rden}, 32'd0);
    @(negedge CLK);
    #1;
    chk("sb_c3_stall", {31'd0, stall}, 32'd0);
    chk("sb_c3_wren", {31'd0, ram_wren}, 32'd1);
    chk("sb_c3_data", ram_data, 32'hDEAD55EF);
    chk("sb_c3_addr", {22'd0, ram_address}, 32'd4);
    MemWrite = 1'b0;

    do_load("lh", 32'h12, 3'b001, 32'hFFFFDEAD);
    do_load("lhu", 32'h12, 3'b101, 32'h0000DEAD);

`ifdef MISALIGN_TRAP_EN
    @(negedge CLK);
    daddr = 32'h11; funct3 = 3'b010; MemRead = 1'b1;
    #1;
    chk("mis_flag", {31'd0, misalign}, 32'd1);
    chk("mis_rden", {31'd0, ram_rden}, 32'd0);
    chk("mis_stall", {31'd0, stall}, 32'd0);
    @(negedge CLK);
    MemRead = 1'b0;
    #1;
    chk("mis_pulse_end", {31'd0, misalign}, 32'd0);
`else
    do_load("lw_unal", 32'h11, 3'b010, 32'hDEAD55EF);
`endif

    // Simultaneous read+write is a store; high address bits wrap
    @(negedge CLK);
    daddr = 32'h20; ddata_w = 32'h12345678; funct3 = 3'b010; MemWrite = 1'b1; MemRead = 1'b1;
    #1;
    chk("rw_wren", {31'd0, ram_wren}, 32'd1);
    chk("rw_rden", {31'd0, ram_rden}, 32'd0);
    chk("rw_stall", {31'd0, stall}, 32'd0);
    @(negedge CLK);
    MemWrite = 1'b0; MemRead = 1'b0;
    do_load("lw_wrap", 32'h1020, 3'b010, 32'h12345678);

    // Reset in the middle of a halfword read-modify-write
    @(negedge CLK);
    daddr = 32'h10; ddata_w = 32'h0000AAAA; funct3 = 3'b001; MemWrite = 1'b1;
    #1;
    chk("shr_c1_rden", {31'd0, ram_rden}, 32'd1);
    @(negedge CLK);
    #1;
    chk("shr_c2_stall", {31'd0, stall}, 32'd1);
    RESET_N = 1'b0; MemWrite = 1'b0;
    #1;
    chk("shr_rst_wren", {31'd0, ram_wren}, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    #1;
    chk("shr_idle_stall", {31'd0, stall}, 32'd0);
    chk("shr_idle_wren", {31'd0, ram_wren}, 32'd0);
    chk("shr_idle_rden", {31'd0, ram_rden}, 32'd0);
    chk("shr_mem4", tb_mem[4], 32'hDEAD55EF);
    do_load("lw_after_rst", 32'h10, 3'b010, 32'hDEAD55EF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
